// File: rtl/homelab_kbd_pkg.sv
// Shared types for the Homelab keyboard matrix: matrix geometry, key index,
// scancode map entry and the key-hold state encoding.
package homelab_kbd_pkg;

    localparam int ROWS_DEF = 10;
    localparam int COLS_DEF = 8;
    localparam int ROW_W    = $clog2(ROWS_DEF);
    localparam int COL_W    = $clog2(COLS_DEF);

    typedef logic [$clog2(ROWS_DEF*COLS_DEF)-1:0] key_idx_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } keymap_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DEFER = 2'd2
    } hold_state_t;

    function automatic keymap_t key_at(input int row, input int col);
        keymap_t e;
        e.valid = 1'b1;
        e.row   = ROW_W'(row);
        e.col   = COL_W'(col);
        return e;
    endfunction

endpackage

// File: rtl/homelab_keymap.sv
// PS/2 set-2 scancode to Homelab matrix position; unmapped codes return valid = 0.
module homelab_keymap
    import homelab_kbd_pkg::*;
(
    input  logic [7:0] key_code,
    output keymap_t    entry
);

    // Pure lookup table, one row of the matrix per group of eight codes.
    always_comb begin
        entry = '0;
        case (key_code)
            8'h29: entry = key_at(0, 0);
            8'h5A: entry = key_at(0, 1);
            8'h72: entry = key_at(0, 2);
            8'h75: entry = key_at(0, 3);
            8'h74: entry = key_at(0, 4);
            8'h6B: entry = key_at(0, 5);
            8'h66: entry = key_at(0, 6);
            8'h0D: entry = key_at(0, 7);
            8'h45: entry = key_at(1, 0);
            8'h16: entry = key_at(1, 1);
            8'h1E: entry = key_at(1, 2);
            8'h26: entry = key_at(1, 3);
            8'h25: entry = key_at(1, 4);
            8'h2E: entry = key_at(1, 5);
            8'h36: entry = key_at(1, 6);
            8'h3D: entry = key_at(1, 7);
            8'h3E: entry = key_at(2, 0);
            8'h1C: entry = key_at(2, 1);
            8'h1B: entry = key_at(2, 2);
            8'h23: entry = key_at(2, 3);
            8'h2B: entry = key_at(2, 4);
            8'h34: entry = key_at(2, 5);
            8'h33: entry = key_at(2, 6);
            8'h3B: entry = key_at(2, 7);
            8'h42: entry = key_at(3, 0);
            8'h4B: entry = key_at(3, 1);
            8'h15: entry = key_at(3, 2);
            8'h1D: entry = key_at(3, 3);
            8'h24: entry = key_at(3, 4);
            8'h2D: entry = key_at(3, 5);
            8'h2C: entry = key_at(3, 6);
            8'h35: entry = key_at(3, 7);
            8'h3C: entry = key_at(4, 0);
            8'h43: entry = key_at(4, 1);
            8'h44: entry = key_at(4, 2);
            8'h4D: entry = key_at(4, 3);
            8'h1A: entry = key_at(4, 4);
            8'h22: entry = key_at(4, 5);
            8'h21: entry = key_at(4, 6);
            8'h2A: entry = key_at(4, 7);
            8'h32: entry = key_at(5, 0);
            8'h31: entry = key_at(5, 1);
            8'h3A: entry = key_at(5, 2);
            8'h46: entry = key_at(5, 3);
            8'h41: entry = key_at(5, 4);
            8'h49: entry = key_at(5, 5);
            8'h4A: entry = key_at(5, 6);
            8'h4E: entry = key_at(5, 7);
            8'h12: entry = key_at(6, 0);
            8'h59: entry = key_at(6, 1);
            8'h14: entry = key_at(6, 2);
            8'h11: entry = key_at(6, 3);
            8'h76: entry = key_at(6, 4);
            8'h05: entry = key_at(6, 5);
            8'h06: entry = key_at(6, 6);
            8'h55: entry = key_at(6, 7);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/homelab_keymatrix.sv
// PS/2 key events from user_io into the Homelab keyboard matrix (CLK12 domain).
// Define HOMELAB_KEY_HOLD_EN to compile in the short-tap stretching machine.
module homelab_keymatrix
    import homelab_kbd_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int HOLD_CYCLES = 240000
) (
    input  logic                 CLK12,
    input  logic                 RESET_N,
    input  logic                 KEY_STROBE,
    input  logic                 KEY_PRESSED,
    input  logic [7:0]           KEY_CODE,
    input  logic [ROWS-1:0]      ROW_SEL_N,
    output logic [COLS-1:0]      COL_OUT_N,
    output logic [ROWS*COLS-1:0] KEY_MATRIX
);

`ifdef HOMELAB_KEY_HOLD_EN
    localparam bit HOLD_BUILD = 1'b1;
`else
    localparam bit HOLD_BUILD = 1'b0;
`endif
    localparam bit HOLD_EN = HOLD_BUILD && (HOLD_CYCLES > 0);

    logic                 strobe_r;
    logic                 armed_r;
    logic [ROWS*COLS-1:0] matrix_r;
    logic [COLS-1:0]      col_any_s;
    keymap_t              km_s;
    logic                 hit_s;
    key_idx_t             idx_s;

    homelab_keymap u_keymap (
        .key_code (KEY_CODE),
        .entry    (km_s)
    );

    // Strobe history; the first edge after reset only arms the detector.
    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            strobe_r <= 1'b0;
            armed_r  <= 1'b0;
        end else begin
            strobe_r <= KEY_STROBE;
            armed_r  <= 1'b1;
        end
    end

    assign hit_s = armed_r && (KEY_STROBE != strobe_r) && km_s.valid
                   && (int'(km_s.row) < ROWS) && (int'(km_s.col) < COLS);
    assign idx_s = key_idx_t'(int'(km_s.row) * COLS + int'(km_s.col));

`ifdef HOMELAB_KEY_HOLD_EN
    if (HOLD_EN) begin : g_hold
        localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
        localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

        hold_state_t      state_r;
        key_idx_t         last_r;
        logic [CNT_W-1:0] cnt_r;
        logic             make_s;
        logic             brk_s;

        assign make_s = hit_s && KEY_PRESSED;
        assign brk_s  = hit_s && !KEY_PRESSED;

        // Hold machine and matrix update; the counter equals HOLD_CYCLES minus
        // edges since the last make, so a deferred clear lands exactly on time.
        always_ff @(posedge CLK12 or negedge RESET_N) begin
            if (!RESET_N) begin
                state_r  <= IDLE;
                last_r   <= '0;
                cnt_r    <= '0;
                matrix_r <= '0;
            end else begin
                cnt_r <= (cnt_r != '0) ? cnt_r - CNT_W'(1) : '0;
                case (state_r)
                    IDLE: begin
                        if (make_s) begin
                            matrix_r[idx_s] <= 1'b1;
                            last_r          <= idx_s;
                            cnt_r           <= CNT_LOAD;
                            state_r         <= HOLD;
                        end else if (brk_s) begin
                            matrix_r[idx_s] <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (make_s) begin
                            matrix_r[idx_s] <= 1'b1;
                            last_r          <= idx_s;
                            cnt_r           <= CNT_LOAD;
                        end else if (brk_s && (idx_s == last_r) && (cnt_r != '0)) begin
                            state_r <= DEFER;
                        end else begin
                            if (brk_s) begin
                                matrix_r[idx_s] <= 1'b0;
                            end
                            if (cnt_r == '0) begin
                                state_r <= IDLE;
                            end
                        end
                    end
                    DEFER: begin
                        if (make_s) begin
                            if (idx_s != last_r) begin
                                matrix_r[last_r] <= 1'b0;
                            end
                            matrix_r[idx_s] <= 1'b1;
                            last_r          <= idx_s;
                            cnt_r           <= CNT_LOAD;
                            state_r         <= HOLD;
                        end else begin
                            if (brk_s && (idx_s != last_r)) begin
                                matrix_r[idx_s] <= 1'b0;
                            end
                            if (cnt_r == '0) begin
                                matrix_r[last_r] <= 1'b0;
                                state_r          <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end
`endif

    if (!HOLD_EN) begin : g_direct
        // Without stretching a make sets and a break clears on the same edge.
        always_ff @(posedge CLK12 or negedge RESET_N) begin
            if (!RESET_N) begin
                matrix_r <= '0;
            end else if (hit_s) begin
                matrix_r[idx_s] <= KEY_PRESSED;
            end
        end
    end

    // Wired-OR of every selected row onto the column lines.
    always_comb begin
        col_any_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!ROW_SEL_N[r]) begin
                col_any_s = col_any_s | matrix_r[r*COLS +: COLS];
            end else begin
                col_any_s = col_any_s;
            end
        end
    end

    assign COL_OUT_N  = ~col_any_s;
    assign KEY_MATRIX = matrix_r;

endmodule

// File: tb/tb_homelab_keymatrix.sv
// Self-checking bench for homelab_keymatrix: directed cases plus random key
// traffic compared against a timestamp-based model of the release rules.
module tb_homelab_keymatrix;

    localparam int ROWS = 10;
    localparam int COLS = 8;
    localparam int NK   = ROWS * COLS;
    localparam int HOLD = 48;
`ifdef HOMELAB_KEY_HOLD_EN
    localparam int EFF_HOLD = HOLD;
`else
    localparam int EFF_HOLD = 0;
`endif

    logic            clk12       = 1'b0;
    logic            reset_n     = 1'b0;
    logic            key_strobe  = 1'b0;
    logic            key_pressed = 1'b0;
    logic [7:0]      key_code    = 8'h00;
    logic [ROWS-1:0] row_sel_n   = '0;
    logic [COLS-1:0] col_out_n;
    logic [NK-1:0]   key_matrix;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: key bits plus the time of the most recent make.
    logic [NK-1:0] m_mat;
    logic          m_prev;
    logic          m_armed;
    logic          m_def;
    int            m_t;
    int            m_last;
    int            m_make_t;

    homelab_keymatrix #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK12       (clk12),
        .RESET_N     (reset_n),
        .KEY_STROBE  (key_strobe),
        .KEY_PRESSED (key_pressed),
        .KEY_CODE    (key_code),
        .ROW_SEL_N   (row_sel_n),
        .COL_OUT_N   (col_out_n),
        .KEY_MATRIX  (key_matrix)
    );

    always #5 clk12 = ~clk12;

    task automatic check_eq(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_index(input logic [7:0] code);
        case (code)
            8'h29:   return 0;
            8'h5A:   return 1;
            8'h1C:   return 2 * COLS + 1;
            8'h1B:   return 2 * COLS + 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [COLS-1:0] model_col(input logic [NK-1:0] mat, input logic [ROWS-1:0] sel);
        logic [COLS-1:0] c;
        c = '1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                if (!sel[r] && mat[r*COLS+k]) c[k] = 1'b0;
        return c;
    endfunction

    task automatic model_reset();
        m_mat    = '0;
        m_prev   = 1'b0;
        m_armed  = 1'b0;
        m_def    = 1'b0;
        m_t      = 0;
        m_last   = 0;
        m_make_t = -1000000;
    endtask

    // A break inside the hold window of the newest make is postponed until
    // HOLD edges after that make; any later make flushes the postponed release.
    task automatic model_edge();
        int   idx;
        logic evt;
        m_t++;
        evt     = m_armed && (key_strobe != m_prev);
        m_prev  = key_strobe;
        m_armed = 1'b1;
        idx     = key_index(key_code);
        if (evt && idx >= 0 && key_pressed) begin
            if (m_def && m_last != idx) m_mat[m_last] = 1'b0;
            m_def       = 1'b0;
            m_mat[idx]  = 1'b1;
            m_last      = idx;
            m_make_t    = m_t;
        end else begin
            if (evt && idx >= 0) begin
                if (idx == m_last && (m_t - m_make_t) < EFF_HOLD) m_def = 1'b1;
                else m_mat[idx] = 1'b0;
            end
            if (m_def && (m_t - m_make_t) >= EFF_HOLD) begin
                m_mat[m_last] = 1'b0;
                m_def         = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk12);
        #1;
        check_eq("matrix", key_matrix, m_mat);
        check_eq("col_out", NK'(col_out_n), NK'(model_col(m_mat, row_sel_n)));
    endtask

    task automatic send(input logic pressed, input logic [7:0] code);
        key_pressed = pressed;
        key_code    = code;
        key_strobe  = ~key_strobe;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0]    codes [5] = '{8'h29, 8'h5A, 8'h1C, 8'h1B, 8'h07};
    logic [NK-1:0] exp_mat;
    int            release_k;

    initial begin
        model_reset();
        key_strobe = 1'b1;
        #2;
        check_eq("reset_matrix", key_matrix, NK'(0));
        check_eq("reset_col", NK'(col_out_n), NK'(8'hFF));
        @(posedge clk12);
        #1;
        reset_n = 1'b1;

        // Strobe already high at release: arming must not raise an event.
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("arm_no_event", key_matrix, NK'(0));
        end

        send(1'b1, 8'h1C);
        exp_mat     = '0;
        exp_mat[17] = 1'b1;
        check_eq("make_a", key_matrix, exp_mat);
        row_sel_n = 10'h3FB;
        #1;
        check_eq("col_a", NK'(col_out_n), NK'(8'hFD));

        send(1'b1, 8'h07);
        check_eq("unmapped_make", key_matrix, exp_mat);
        send(1'b0, 8'h07);
        check_eq("unmapped_break", key_matrix, exp_mat);

        send(1'b1, 8'h1B);
        #1;
        check_eq("col_as", NK'(col_out_n), NK'(8'hF9));
        row_sel_n = 10'h3FF;
        #1;
        check_eq("col_none", NK'(col_out_n), NK'(8'hFF));

        // Reset in the middle of a hold drops everything, pending release included.
        send(1'b0, 8'h1B);
        row_sel_n = 10'h000;
        reset_n   = 1'b0;
        #1;
        check_eq("midhold_reset", key_matrix, NK'(0));
        check_eq("midhold_col", NK'(col_out_n), NK'(8'hFF));
        model_reset();
        @(posedge clk12);
        #1;
        reset_n = 1'b1;
        idle(HOLD + 4);

        // Short tap: break 12 cycles after the make.
        release_k = (EFF_HOLD > 0) ? EFF_HOLD : 12;
        send(1'b1, 8'h29);
        check_eq("tap_make", NK'(key_matrix[0]), NK'(1));
        for (int k = 1; k <= HOLD + 2; k++) begin
            if (k == 12) send(1'b0, 8'h29);
            else step();
            check_eq("tap_hold", NK'(key_matrix[0]), NK'(k < release_k));
        end

        // Deferred release flushed by a make of another key on the same edge.
        send(1'b1, 8'h29);
        for (int k = 1; k <= 30; k++) begin
            if (k == 20) send(1'b0, 8'h29);
            else if (k == 30) send(1'b1, 8'h5A);
            else step();
            if (k == 29) check_eq("swap_before", NK'(key_matrix[0]), NK'(EFF_HOLD > 0));
        end
        check_eq("swap_bit0", NK'(key_matrix[0]), NK'(0));
        check_eq("swap_bit1", NK'(key_matrix[1]), NK'(1));
        send(1'b0, 8'h5A);
        idle(HOLD + 2);
        check_eq("swap_settled", key_matrix, NK'(0));

        // Random traffic in bursts of dense and sparse events.
        for (int b = 0; b < 40; b++) begin
            int len;
            int rate;
            len  = $urandom_range(80, 10);
            rate = ($urandom_range(1, 0) == 0) ? 2 : 16;
            for (int i = 0; i < len; i++) begin
                row_sel_n = ROWS'($urandom);
                if ($urandom_range(rate - 1, 0) == 0)
                    send(1'($urandom_range(1, 0)), codes[$urandom_range(4, 0)]);
                else
                    step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/homelab_keymatrix.md
# homelab_keymatrix

Converts the PS/2 set-2 key events delivered by the MiST user_io block (KEY_STROBE / KEY_PRESSED / KEY_CODE) into the Homelab keyboard matrix that the CPU reads.

- Sits directly downstream of user_io and directly upstream of the Homelab core's keyboard address decode, all in the CLK12 domain.
- Holds one state bit per matrix key.
- Optionally stretches very short host key taps so the CPU's software scan cannot miss them.

## Interface
Parameters:
- ROWS, 10, number of matrix rows (CPU row-select lines).
- COLS, 8, number of matrix columns (CPU data bits).
- HOLD_CYCLES, 240000, minimum asserted time of the most recently pressed key, in CLK12 cycles (20 ms); 0 disables stretching.

Ports:
- CLK12  input  1  system clock, 12 MHz. This is the only clock.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY_STROBE  input  1  toggle from user_io; every change marks one new key event.
- KEY_PRESSED  input  1  1 = make, 0 = break; valid on the cycle KEY_STROBE changes.
- KEY_CODE  input  8  PS/2 set-2 scancode; valid on the cycle KEY_STROBE changes.
- ROW_SEL_N  input  ROWS  active-low row select from the CPU address bus; several rows may be selected at once.
- COL_OUT_N  output  COLS  active-low column data; bit c is 0 if any selected row has key (r,c) down.
- KEY_MATRIX  output  ROWS*COLS  raw key-down bits (1 = down), index r*COLS+c, for debug and on-screen display.

## Operation
- Event detect: a register stores the previous KEY_STROBE value. An event fires when KEY_STROBE differs from that register.
- Arming: the first CLK12 cycle after RESET_N deasserts only loads the register and generates no event.
- Decode: sub-module homelab_keymap maps KEY_CODE to {valid, row, col}. Codes with valid = 0 are ignored with no state change.
- Required map entries: 0x29 space → (0,0); 0x5A enter → (0,1); 0x1C A → (2,1); 0x1B S → (2,2).
- Make event: sets the key's bit. Break event: clears the key's bit, unless a deferred release applies (see state machine).
- COL_OUT_N[c] = ~OR over r of (~ROW_SEL_N[r] & KEY_MATRIX[r*COLS+c]). This path is combinational from the registered state.
- Hold state machine (HOLD_CYCLES > 0): stores last_idx, the key index, and a down-counter.
  - IDLE → HOLD on a make of any key: last_idx = key, counter = HOLD_CYCLES-1.
  - HOLD: counter decrements each cycle.
    - Counter reaches 0 → IDLE.
    - Break of last_idx with counter ≠ 0 → DEFER; the bit stays set.
  - DEFER: counter keeps decrementing. Counter reaches 0 → clear bit last_idx, go to IDLE.
  - Make of a different key in HOLD or DEFER: in that same cycle, clear the deferred bit (DEFER only), set the new key's bit, reload the counter, go to HOLD.
  - Make of last_idx while in DEFER: cancel the deferral, keep the bit set, reload the counter, go to HOLD.
  - Breaks of keys other than last_idx: always cleared immediately.
- Repeated make of a key already down: bit stays set. In IDLE or HOLD it is handled as a new make, so it reloads the counter.

## Timing
- Reset values: KEY_MATRIX = 0, COL_OUT_N = all 1s, state = IDLE, counter = 0, strobe register = 0, not armed.
- Latency: a KEY_STROBE change on cycle n is visible on KEY_MATRIX and COL_OUT_N after the CLK12 edge ending cycle n.
- ROW_SEL_N → COL_OUT_N: combinational, zero cycles.
- Event throughput: one event per cycle.
- Deferred clear occurs on the edge where the counter reaches 0. Total asserted time is exactly HOLD_CYCLES cycles from the make edge.
- Reset asserted mid-hold: all state is cleared asynchronously and the pending release is discarded.
- Counter width is $clog2(HOLD_CYCLES+1). It never wraps: it saturates at 0 in IDLE.

## Configuration
- HOMELAB_KEY_HOLD_EN defined: the hold state machine and counter are compiled in, as described above.
- HOMELAB_KEY_HOLD_EN undefined: no state machine and no counter. Every break clears its bit in the same cycle as its make would set it, and HOLD_CYCLES is ignored.

## Structure
- Package homelab_kbd_pkg holds:
  - ROWS_DEF and COLS_DEF.
  - The typedef key_idx_t, sized $clog2(ROWS*COLS).
  - The typedef keymap_t {valid, row, col}.
  - The hold_state_t enum {IDLE, HOLD, DEFER}.
- Sub-module homelab_keymap: a purely combinational case table, KEY_CODE → keymap_t.

## Test plan
- Reset, then KEY_STROBE toggles with KEY_PRESSED = 1, KEY_CODE = 0x1C → KEY_MATRIX bit 17 = 1 one cycle later. With ROW_SEL_N = 10'h3FB, COL_OUT_N = 8'hFD.
- RESET_N released while KEY_STROBE = 1, held static for 10 cycles → KEY_MATRIX remains 0 (no spurious event).
- Make then break of 0x29 after 100 cycles, HOLD_CYCLES = 1000 → bit 0 stays 1 until exactly cycle 1000 after the make, then 0. Without HOMELAB_KEY_HOLD_EN → bit 0 drops at cycle 101.
- Make 0x29, break 0x29 at cycle 50, make 0x5A at cycle 60 → bit 0 clears and bit 1 sets on the same edge (cycle 61).
- Unmapped code 0x07 make/break → no KEY_MATRIX change and state stays IDLE.
- Both 0x1C and 0x1B down, ROW_SEL_N = 10'h3FB → COL_OUT_N = 8'hF9. With ROW_SEL_N = 10'h3FF → COL_OUT_N = 8'hFF.
